// File: rtl/pc_update_unit.sv
// Program-counter register and next-PC selection for the single-cycle core,
// with pc+4, redirect flag, retired-instruction counter and sticky select error.
module pc_update_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic [1:0]           pc_sel,
    input  logic [15:0]          branch_imm,
    input  logic [25:0]          jump_addr,
    output logic [31:0]          pc,
    output logic [31:0]          pc_plus4,
    output logic                 redirect,
    output logic [CNT_WIDTH-1:0] retired_count,
    output logic                 sel_err
);

    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [31:0]          pc_d, pc_q;
    logic                 redirect_d, redirect_q;
    logic [CNT_WIDTH-1:0] count_d, count_q;
    logic                 sel_err_d, sel_err_q;

    logic [31:0] seq_target_s;
    logic [31:0] branch_target_s;
    logic [31:0] jump_target_s;

    // Sign-extended word offset expressed as a byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        branch_offset = {{14{imm[15]}}, imm, 2'b00};
    endfunction

    // Candidate targets; all arithmetic wraps modulo 2^32.
    always_comb begin
        seq_target_s    = pc_q + 32'd4;
        branch_target_s = seq_target_s + branch_offset(branch_imm);
        jump_target_s   = {seq_target_s[31:28], jump_addr, 2'b00};
    end

    // Next-state selection; a stall holds everything except redirect.
    always_comb begin
        pc_d       = pc_q;
        redirect_d = 1'b0;
        count_d    = count_q;
        sel_err_d  = sel_err_q;
        if (!stall) begin
            count_d = count_q + CNT_ONE;
            case (pc_sel)
                SEL_SEQ: begin
                    pc_d = seq_target_s;
                end
                SEL_BRANCH: begin
                    pc_d       = branch_target_s;
                    redirect_d = 1'b1;
                end
                SEL_JUMP: begin
                    pc_d       = jump_target_s;
                    redirect_d = 1'b1;
                end
                default: begin
                    // Illegal select falls back to sequential flow and latches the error.
                    pc_d      = seq_target_s;
                    sel_err_d = 1'b1;
                end
            endcase
        end else begin
            pc_d       = pc_q;
            redirect_d = 1'b0;
        end
    end

    // State registers with synchronous reset taking priority over stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_VECTOR;
            redirect_q <= 1'b0;
            count_q    <= {CNT_WIDTH{1'b0}};
            sel_err_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            count_q    <= count_d;
            sel_err_q  <= sel_err_d;
        end
    end

    // Output mapping.
    always_comb begin
        pc            = pc_q;
        pc_plus4      = seq_target_s;
        redirect      = redirect_q;
        retired_count = count_q;
        sel_err       = sel_err_q;
    end

endmodule
